mips_multi_cycle: RTL
=====================

// Module: mips_multi_cycle
// PURPOSE
//  Parametrised multi-cycle MIPS-subset core; successor to the single-cycle datapath.
//  One shared ALU and an FSM sequence each instruction over 2-5 cycles.
//  Private instruction memory (IMEM), loaded through a program port; private data memory (DMEM).
//  Adds halt/illegal detection, a per-instruction retire strobe and a register debug read port.
// PARAMETERS
//  IMEM_WORDS  1024  IMEM depth in 32-bit words (power of 2); IA=$clog2(IMEM_WORDS)
//  DMEM_WORDS  1024  DMEM depth in 32-bit words (power of 2); DA=$clog2(DMEM_WORDS)
//  RESET_PC    0     PC value loaded on reset (word aligned)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  prog_we       in   1   IMEM write enable
//  prog_addr     in   IA  IMEM word address for prog_we
//  prog_data     in   32  IMEM write data
//  dbg_reg_addr  in   5   register-file debug read index
//  dbg_reg_data  out  32  combinational read of reg[dbg_reg_addr]; index 0 always reads 0
//  pc_out        out  32  current PC
//  state_out     out  3   FSM state encoding
//  retire        out  1   1-cycle pulse when an instruction completes
//  halted        out  1   sticky; set on HALT opcode
//  illegal       out  1   sticky; set on unsupported opcode/funct
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, IR/A/B/ALUOut/MDR=0, all 32 regs=0; retire, halted, illegal=0.
//   Reset wins over everything, mid-instruction included. IMEM/DMEM are not cleared.
//   prog_we writes IMEM on any edge, even during reset (program loading is done under reset).
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5. Codes 6 and 7 go to HALT with illegal=1.
//  FETCH:  IR<=imem[pc[IA+1:2]]; pc<=pc+4; ->DECODE. Upper PC bits ignored (index wraps).
//  DECODE: A<=reg[rs]; B<=reg[rt]. Then by opcode:
//    6'h3F -> HALT, halted<=1.
//    Not in {00,02,04,08,23,2B}, or R-type funct not in {20,22,24,25,2A} -> HALT, illegal<=1.
//    j(02): pc<={pc[31:28],IR[25:0],2'b00}; retire; ->FETCH (2 cycles total).
//    Otherwise ->EXEC.
//  EXEC:   ALUOut<=A op (R ? B : sext(imm16)).
//    add/addi and address calc use add mod 2^32; overflow ignored.
//    sub=A-B; and; or; slt = signed A<B ? 1 : 0.
//    beq(04): if A==B then pc<=pc+(sext(imm)<<2), where pc is already PC+4; retire; ->FETCH.
//    R-type/addi ->WB. lw/sw ->MEM.
//  MEM:    address index = ALUOut[DA+1:2]; ALUOut[1:0] ignored; index wraps modulo DMEM_WORDS.
//    sw(2B): dmem<=B; retire; ->FETCH.
//    lw(23): MDR<=dmem; ->WB.
//  WB:     dest = rd for R-type, else rt; data = MDR for lw, else ALUOut. Writes to reg 0 dropped.
//    retire; ->FETCH.
//  HALT:   absorbing. pc frozen; no reg/DMEM writes; retire stays 0. Exit only by reset.
//  Cycles per instruction: j 2, beq 3, R/addi 4, sw 4, lw 5.
//  retire is registered: high exactly the one cycle after the completing state's edge.
//  Only one instruction is in flight; no hazards exist. Read-after-write through regs is naturally correct.
// TESTING
//  T1 Under reset: load addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; HALT.
//     Release reset -> reg3=2, halted=1 after 4+4+4+2 cycles (FETCH/DECODE for HALT); 3 retire pulses.
//  T2 sw $1,8($0) with $1=0xDEADBEEF, then lw $4,8($0)
//     -> reg4=0xDEADBEEF; lw retire arrives exactly 5 cycles after its FETCH.
//  T3 beq $0,$0,-1 at pc=0x10 -> pc returns to 0x10 every 3 cycles.
//     beq $1,$0,+2 with $1!=0 -> pc=0x14.
//  T4 j 0x40 at pc=0x0 -> pc=0x100 two cycles after FETCH. slt $5,$2,$1 with $2=-3,$1=5 -> reg5=1.
//  T5 Opcode 6'h3E, or R funct 6'h3F -> illegal=1, state=5; pc and regs frozen for 20 cycles.
//     addi $0,$0,7 -> reg0 still reads 0.
//  T6 Assert reset during the MEM state of sw -> DMEM unchanged, pc=RESET_PC, regs 0, state=0 next cycle.
//     Rerun with RESET_PC=0x20, DMEM_WORDS=16: address 0x44 aliases word 1.

Source files
------------

// File: rtl/mips_multi_cycle_if.sv
// Program-load, register-debug and status bundle of the multi-cycle MIPS core.
// The master side loads the program and observes state; the core is the slave side.
interface mips_multi_cycle_if #(
    parameter int IA = 10
);
    logic          prog_we;
    logic [IA-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic [4:0]    dbg_reg_addr;
    logic [31:0]   dbg_reg_data;
    logic [31:0]   pc_out;
    logic [2:0]    state_out;
    logic          retire;
    logic          halted;
    logic          illegal;

    modport master (
        output prog_we, prog_addr, prog_data, dbg_reg_addr,
        input  dbg_reg_data, pc_out, state_out, retire, halted, illegal
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, dbg_reg_addr,
        output dbg_reg_data, pc_out, state_out, retire, halted, illegal
    );
endinterface

// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-subset core: one shared ALU sequenced by a FETCH/DECODE/EXEC/MEM/WB FSM,
// private program-loaded IMEM and private DMEM, sticky halt/illegal flags and a retire strobe.
module mips_multi_cycle #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    mips_multi_cycle_if.slave bus
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic        retire_reg, retire_next;
    logic        halted_reg, halted_next;
    logic        illegal_reg, illegal_next;
    logic        ir_load, ab_load, alu_load, mdr_load, dmem_we, reg_we;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] regs [32];

    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, wb_dest;
    logic [31:0]   imm_sext, alu_b, alu_res, wb_data;
    logic          is_rtype, instr_legal;
    logic [IA-1:0] imem_idx;
    logic [DA-1:0] dmem_idx;
    logic          unused_shamt;

    assign opcode       = ir_reg[31:26];
    assign rs           = ir_reg[25:21];
    assign rt           = ir_reg[20:16];
    assign rd           = ir_reg[15:11];
    assign funct        = ir_reg[5:0];
    assign unused_shamt = ^ir_reg[10:6];
    assign imm_sext     = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign is_rtype     = (opcode == OP_RTYPE);
    assign imem_idx     = pc_reg[IA+1:2];
    assign dmem_idx     = alu_out_reg[DA+1:2];
    assign wb_dest      = is_rtype ? rd : rt;
    assign wb_data      = (opcode == OP_LW) ? mdr_reg : alu_out_reg;

    always_comb begin
        instr_legal = 1'b0;
        case (opcode)
            OP_RTYPE: instr_legal = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                                    (funct == 6'h25) || (funct == 6'h2A);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: instr_legal = 1'b1;
            default: instr_legal = 1'b0;
        endcase
    end

    // Shared ALU: immediate forms (addi, lw/sw address) always add.
    always_comb begin
        alu_b   = is_rtype ? b_reg : imm_sext;
        alu_res = a_reg + alu_b;
        if (is_rtype) begin
            case (funct)
                6'h22:   alu_res = a_reg - b_reg;
                6'h24:   alu_res = a_reg & b_reg;
                6'h25:   alu_res = a_reg | b_reg;
                6'h2A:   alu_res = {31'd0, ($signed(a_reg) < $signed(b_reg))};
                default: alu_res = a_reg + b_reg;
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        retire_next  = 1'b0;
        halted_next  = halted_reg;
        illegal_next = illegal_reg;
        ir_load      = 1'b0;
        ab_load      = 1'b0;
        alu_load     = 1'b0;
        mdr_load     = 1'b0;
        dmem_we      = 1'b0;
        reg_we       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_load    = 1'b1;
                pc_next    = pc_reg + 32'd4;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ab_load = 1'b1;
                if (opcode == OP_HALT) begin
                    halted_next = 1'b1;
                    state_next  = S_HALT;
                end else if (!instr_legal) begin
                    illegal_next = 1'b1;
                    state_next   = S_HALT;
                end else if (opcode == OP_J) begin
                    pc_next     = {pc_reg[31:28], ir_reg[25:0], 2'b00};
                    retire_next = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_load = 1'b1;
                if (opcode == OP_BEQ) begin
                    // pc already holds PC+4 from FETCH
                    if (a_reg == b_reg) pc_next = pc_reg + {imm_sext[29:0], 2'b00};
                    retire_next = 1'b1;
                    state_next  = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (opcode == OP_SW) begin
                    dmem_we     = 1'b1;
                    retire_next = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    mdr_load   = 1'b1;
                    state_next = S_WB;
                end
            end
            S_WB: begin
                reg_we      = 1'b1;
                retire_next = 1'b1;
                state_next  = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: begin
                illegal_next = 1'b1;
                state_next   = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
            retire_reg  <= 1'b0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retire_reg  <= retire_next;
            halted_reg  <= halted_next;
            illegal_reg <= illegal_next;
            if (ir_load) ir_reg <= imem[imem_idx];
            if (ab_load) begin
                a_reg <= regs[rs];
                b_reg <= regs[rt];
            end
            if (alu_load) alu_out_reg <= alu_res;
            if (mdr_load) mdr_reg <= dmem[dmem_idx];
        end
    end

    // Program loading is allowed while the core is held in reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we) imem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && dmem_we) dmem[dmem_idx] <= b_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we && wb_dest != 5'd0) begin
            regs[wb_dest] <= wb_data;
        end
    end

    assign bus.dbg_reg_data = (bus.dbg_reg_addr == 5'd0) ? 32'd0 : regs[bus.dbg_reg_addr];
    assign bus.pc_out       = pc_reg;
    assign bus.state_out    = state_reg;
    assign bus.retire       = retire_reg;
    assign bus.halted       = halted_reg;
    assign bus.illegal      = illegal_reg;
endmodule
